tnet_link_ctrl: RTL and testbench

// Parametrised tnet ring-link controller between one Aurora RX/TX lane pair and the local tnet core.

---
 rtl/tnet_pkg.sv | 34 +++
 rtl/tnet_hdr_decode.sv | 34 +++
 rtl/tnet_link_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_tnet_link_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnet_pkg.sv
// Shared types for the tnet ring link: FSM state encoding, header field layout
// and the forwarding hop-count helper.
package tnet_pkg;

  typedef enum logic [3:0] {
    ST_NOT_READY = 4'd0,
    ST_IDLE      = 4'd1,
    ST_RX_H      = 4'd2,
    ST_RX_D      = 4'd3,
    ST_DECIDE    = 4'd4,
    ST_DELIVER   = 4'd5,
    ST_FWD_H     = 4'd6,
    ST_FWD_D     = 4'd7,
    ST_TX_H      = 4'd8,
    ST_TX_D      = 4'd9,
    ST_WAIT_NREQ = 4'd10,
    ST_RX_DRAIN  = 4'd11
  } state_e;

  // Header layout (fixed for 10-bit node fields); bits above HDR_W pass through.
  localparam int HDR_W    = 56;
  localparam int FIELD_W  = 10;
  localparam int DST_LSB  = 40;
  localparam int SRC_LSB  = 30;
  localparam int STEP_LSB = 20;

  function automatic logic [HDR_W-1:0] step_inc(input logic [HDR_W-1:0] hdr);
    logic [HDR_W-1:0] r;
    r = hdr;
    r[STEP_LSB +: FIELD_W] = hdr[STEP_LSB +: FIELD_W] + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tnet_hdr_decode.sv
// Combinational routing decision for a captured header: exactly one of
// deliver / forward / stale is high; stale takes precedence.
module tnet_hdr_decode
  import tnet_pkg::*;
#(
  parameter int AW      = 10,
  parameter int HOP_MAX = 1023
) (
  input  logic [HDR_W-1:0] hdr,
  input  logic [AW-1:0]    id,
  input  logic [AW-1:0]    nn,
  output logic             deliver,
  output logic             forward,
  output logic             stale
);

  logic [AW-1:0] dst;
  logic [AW-1:0] src;
  logic [AW-1:0] step;
  logic          to_me;
  logic          unused_bits;

  assign dst  = hdr[DST_LSB +: AW];
  assign src  = hdr[SRC_LSB +: AW];
  assign step = hdr[STEP_LSB +: AW];
  assign unused_bits = ^{hdr[HDR_W-1:DST_LSB+AW], hdr[STEP_LSB-1:0]};

  // Our own packets coming back round the ring are consumed, not re-forwarded.
  assign to_me   = (dst == id && id != '0) || (src == id) || (&dst);
  assign stale   = (nn != '0) && (step == AW'(HOP_MAX));
  assign deliver = !stale && to_me;
  assign forward = !stale && !to_me;

endmodule

// File: rtl/tnet_link_ctrl.sv
// tnet ring-link controller: receives Aurora packets, delivers, forwards (hop+1)
// or drops them, and muxes local TX requests onto the same TX lane.
module tnet_link_ctrl
  import tnet_pkg::*;
#(
  parameter int DW          = 64,
  parameter int DATA_WORDS  = 1,
  parameter int AW          = 10,
  parameter int HOP_MAX     = 1023,
  parameter int TIMEOUT_CYC = 512
) (
  input  logic                     user_clk_i,
  input  logic                     user_rst_i,
  input  logic [AW-1:0]            id_i,
  input  logic [AW-1:0]            nn_i,
  input  logic                     channel_ok_i,
  input  logic                     tx_req_i,
  input  logic [DW-1:0]            tx_header_i,
  input  logic [DW*DATA_WORDS-1:0] tx_data_i,
  output logic                     tx_ack_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [DW-1:0]            cmd_header_o,
  output logic [DW*DATA_WORDS-1:0] cmd_data_o,
  input  logic [DW-1:0]            s_axi_rx_tdata,
  input  logic                     s_axi_rx_tvalid,
  input  logic                     s_axi_rx_tlast,
  output logic [DW-1:0]            m_axi_tx_tdata,
  output logic                     m_axi_tx_tvalid,
  output logic                     m_axi_tx_tlast,
  input  logic                     m_axi_tx_tready,
  output logic                     ready_o,
  output logic [7:0]               rx_cnt_o,
  output logic [7:0]               drop_cnt_o,
  output logic [3:0]               state_o
);

  localparam int CW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_W   = CW'(DATA_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           wcnt_q;
  logic [TW-1:0]           tmo_q;
  logic [DW-1:0]           hdr_q;
  logic [DW*DATA_WORDS-1:0] pay_q;
  logic                    rx_skip_q;
  logic [7:0]              rx_cnt_q, drop_cnt_q;
  logic                    dec_deliver, dec_forward, dec_stale;
  logic                    rx_live, rx_stray, in_rest, word_last, enter_nr;
  logic                    pkt_drop, pkt_rx_end;
  logic [1:0]              drop_inc;
  logic [8:0]              drop_sum;
  logic [DW-1:0]           fwd_hdr;

  tnet_hdr_decode #(.AW(AW), .HOP_MAX(HOP_MAX)) u_decode (
    .hdr     (hdr_q[HDR_W-1:0]),
    .id      (id_i),
    .nn      (nn_i),
    .deliver (dec_deliver),
    .forward (dec_forward),
    .stale   (dec_stale)
  );

  // IDLE ignores the tail of a packet whose header arrived while we were busy.
  assign rx_live   = (state_q == ST_IDLE && !rx_skip_q) || state_q == ST_RX_H ||
                     state_q == ST_RX_D || state_q == ST_RX_DRAIN;
  assign rx_stray  = s_axi_rx_tvalid && !rx_live;
  assign in_rest   = (state_q == ST_IDLE) || (state_q == ST_NOT_READY);
  assign word_last = (wcnt_q == LAST_W);
  assign enter_nr  = (state_d == ST_NOT_READY) && (state_q != ST_NOT_READY);

  always_comb begin
    fwd_hdr = hdr_q;
    fwd_hdr[HDR_W-1:0] = step_inc(hdr_q[HDR_W-1:0]);
  end

  always_comb begin
    state_d    = state_q;
    pkt_drop   = 1'b0;
    pkt_rx_end = 1'b0;
    case (state_q)
      ST_NOT_READY: if (channel_ok_i) state_d = ST_IDLE;
      ST_IDLE: begin
        if (s_axi_rx_tvalid && !rx_skip_q) begin
          if (s_axi_rx_tlast) pkt_drop = 1'b1;
          else                state_d  = ST_RX_H;
        end else if (tx_req_i) begin
          state_d = ST_TX_H;
        end
      end
      // Header was latched on entry to RX_H; both states capture payload beats.
      ST_RX_H, ST_RX_D: begin
        if (s_axi_rx_tvalid) begin
          if (s_axi_rx_tlast) begin
            pkt_rx_end = 1'b1;
            if (word_last) state_d = ST_DECIDE;
            else begin
              pkt_drop = 1'b1;
              state_d  = ST_IDLE;
            end
          end else if (word_last) begin
            state_d = ST_RX_DRAIN;
          end else begin
            state_d = ST_RX_D;
          end
        end
      end
      ST_RX_DRAIN: begin
        if (s_axi_rx_tvalid && s_axi_rx_tlast) begin
          pkt_rx_end = 1'b1;
          pkt_drop   = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_DECIDE: begin
        if (dec_stale) begin
          pkt_drop = 1'b1;
          state_d  = ST_IDLE;
        end else if (dec_deliver) state_d = ST_DELIVER;
        else if (dec_forward)     state_d = ST_FWD_H;
      end
      ST_DELIVER:   if (cmd_ready_i) state_d = ST_IDLE;
      ST_FWD_H:     if (m_axi_tx_tready) state_d = ST_FWD_D;
      ST_FWD_D:     if (m_axi_tx_tready && word_last) state_d = ST_IDLE;
      ST_TX_H:      if (m_axi_tx_tready) state_d = ST_TX_D;
      ST_TX_D:      if (m_axi_tx_tready && word_last) state_d = ST_WAIT_NREQ;
      ST_WAIT_NREQ: if (!tx_req_i) state_d = ST_IDLE;
      default:      state_d = ST_NOT_READY;
    endcase
    if (!in_rest && tmo_q == TMO_LAST) state_d = ST_NOT_READY;
    if (!channel_ok_i)                 state_d = ST_NOT_READY;
  end

  always_comb begin
    m_axi_tx_tdata  = '0;
    m_axi_tx_tvalid = 1'b0;
    m_axi_tx_tlast  = 1'b0;
    case (state_q)
      ST_FWD_H: begin
        m_axi_tx_tvalid = 1'b1;
        m_axi_tx_tdata  = fwd_hdr;
      end
      ST_FWD_D: begin
        m_axi_tx_tvalid = 1'b1;
        m_axi_tx_tdata  = pay_q[int'(wcnt_q)*DW +: DW];
        m_axi_tx_tlast  = word_last;
      end
      ST_TX_H: begin
        m_axi_tx_tvalid = 1'b1;
        m_axi_tx_tdata  = tx_header_i;
      end
      ST_TX_D: begin
        m_axi_tx_tvalid = 1'b1;
        m_axi_tx_tdata  = tx_data_i[int'(wcnt_q)*DW +: DW];
        m_axi_tx_tlast  = word_last;
      end
      default: ;
    endcase
  end

  assign drop_inc = {1'b0, enter_nr} + {1'b0, pkt_drop} + {1'b0, rx_stray && s_axi_rx_tlast};
  assign drop_sum = {1'b0, drop_cnt_q} + {7'b0, drop_inc};

  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      state_q    <= ST_NOT_READY;
      wcnt_q     <= '0;
      tmo_q      <= '0;
      hdr_q      <= '0;
      pay_q      <= '0;
      rx_skip_q  <= 1'b0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= in_rest ? '0 : tmo_q + 1'b1;
      if (state_q == ST_RX_H || state_q == ST_RX_D) begin
        if (s_axi_rx_tvalid) begin
          pay_q[int'(wcnt_q)*DW +: DW] <= s_axi_rx_tdata;
          wcnt_q <= wcnt_q + 1'b1;
        end
      end else if (state_q == ST_FWD_D || state_q == ST_TX_D) begin
        if (m_axi_tx_tready) wcnt_q <= wcnt_q + 1'b1;
      end else begin
        wcnt_q <= '0;
      end
      if (state_q == ST_IDLE && s_axi_rx_tvalid && !rx_skip_q) hdr_q <= s_axi_rx_tdata;
      if (rx_stray) rx_skip_q <= !s_axi_rx_tlast;
      if (pkt_rx_end) rx_cnt_q <= rx_cnt_q + 1'b1;
      drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  assign cmd_valid_o  = (state_q == ST_DELIVER);
  assign cmd_header_o = hdr_q;
  assign cmd_data_o   = pay_q;
  assign tx_ack_o     = (state_q == ST_TX_H) || (state_q == ST_TX_D) || (state_q == ST_WAIT_NREQ);
  assign ready_o      = (state_q != ST_NOT_READY);
  assign rx_cnt_o     = rx_cnt_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_tnet_link_ctrl.sv
// Bench for tnet_link_ctrl (DATA_WORDS=2): routing table plus hand-written
// sequences for latency, backpressure, timeout and link-loss corner cases.
module tb_tnet_link_ctrl;
  import tnet_pkg::*;

  localparam int DW = 64;
  localparam int NW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [9:0]      id_i = 10'd3;
  logic [9:0]      nn_i = 10'd8;
  logic            channel_ok = 1'b0;
  logic            tx_req = 1'b0;
  logic [DW-1:0]   tx_header = '0;
  logic [DW*NW-1:0] tx_data = '0;
  logic            tx_ack;
  logic            cmd_valid;
  logic            cmd_ready = 1'b0;
  logic [DW-1:0]   cmd_header;
  logic [DW*NW-1:0] cmd_data;
  logic [DW-1:0]   rx_tdata = '0;
  logic            rx_tvalid = 1'b0;
  logic            rx_tlast = 1'b0;
  logic [DW-1:0]   tx_tdata;
  logic            tx_tvalid;
  logic            tx_tlast;
  logic            tx_tready = 1'b0;
  logic            ready;
  logic [7:0]      rx_cnt, drop_cnt;
  logic [3:0]      state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_rx   = 0;
  int exp_drop = 0;

  logic [DW:0]          tx_exp_q[$];
  logic [DW*(NW+1)-1:0] cmd_exp_q[$];

  tnet_link_ctrl #(.DW(DW), .DATA_WORDS(NW), .AW(10), .HOP_MAX(1023), .TIMEOUT_CYC(512)) dut (
    .user_clk_i(clk), .user_rst_i(rst), .id_i(id_i), .nn_i(nn_i),
    .channel_ok_i(channel_ok), .tx_req_i(tx_req), .tx_header_i(tx_header),
    .tx_data_i(tx_data), .tx_ack_o(tx_ack), .cmd_valid_o(cmd_valid),
    .cmd_ready_i(cmd_ready), .cmd_header_o(cmd_header), .cmd_data_o(cmd_data),
    .s_axi_rx_tdata(rx_tdata), .s_axi_rx_tvalid(rx_tvalid), .s_axi_rx_tlast(rx_tlast),
    .m_axi_tx_tdata(tx_tdata), .m_axi_tx_tvalid(tx_tvalid), .m_axi_tx_tlast(tx_tlast),
    .m_axi_tx_tready(tx_tready), .ready_o(ready), .rx_cnt_o(rx_cnt),
    .drop_cnt_o(drop_cnt), .state_o(state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_hdr(input logic [9:0] dst, input logic [9:0] src,
                                           input logic [9:0] step, input logic [19:0] lo);
    return {8'hC3, 6'h2A, dst, src, step, lo};
  endfunction

  // scoreboard: compare on handshake cycles, sampled at negedge
  always @(negedge clk) begin
    if (tx_tvalid && tx_tready) begin
      if (tx_exp_q.size() == 0) check("tx_unexpected", {tx_tlast, tx_tdata}, '0);
      else check("tx_word", {tx_tlast, tx_tdata}, tx_exp_q.pop_front());
    end
    if (cmd_valid && cmd_ready) begin
      if (cmd_exp_q.size() == 0) check("cmd_unexpected", {cmd_header, cmd_data}, '0);
      else check("cmd_pkt", {cmd_header, cmd_data}, cmd_exp_q.pop_front());
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_pkt(input logic [DW-1:0] hdr, input logic [DW*NW-1:0] pay,
                        input int last_at, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      rx_tvalid = 1'b1;
      rx_tdata  = (i == 0) ? hdr : pay[((i - 1) % NW)*DW +: DW];
      rx_tlast  = (i == last_at);
      step_clk();
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic push_fwd(input logic [9:0] dst, input logic [9:0] src, input logic [9:0] step,
                          input logic [19:0] lo, input logic [DW*NW-1:0] pay);
    logic [9:0] s1;
    s1 = step + 10'd1;
    tx_exp_q.push_back({1'b0, mk_hdr(dst, src, s1, lo)});
    tx_exp_q.push_back({1'b0, pay[DW-1:0]});
    tx_exp_q.push_back({1'b1, pay[2*DW-1:DW]});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((state != ST_IDLE || tx_exp_q.size() != 0 || cmd_exp_q.size() != 0) && n < budget) begin
      step_clk();
      n++;
    end
    check(name, (n < budget), 1'b1);
  endtask

  task automatic check_cnts(input string name);
    check({name, "_rx_cnt"}, rx_cnt, exp_rx[7:0]);
    check({name, "_drop_cnt"}, drop_cnt, exp_drop[7:0]);
  endtask

  typedef struct {
    logic [9:0] id;
    logic [9:0] nn;
    logic [9:0] dst;
    logic [9:0] src;
    logic [9:0] step;
    int         kind;  // 0 deliver, 1 forward, 2 drop
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [DW-1:0]    h;
    logic [DW*NW-1:0] p;
    logic [19:0]      lo;
    int               n;

    vecs[0] = '{10'd3, 10'd8, 10'd3,    10'd9, 10'd0,    0};
    vecs[1] = '{10'd3, 10'd8, 10'd20,   10'd3, 10'd5,    0};
    vecs[2] = '{10'd3, 10'd8, 10'd1023, 10'd9, 10'd7,    0};
    vecs[3] = '{10'd0, 10'd8, 10'd0,    10'd9, 10'd1,    1};
    vecs[4] = '{10'd3, 10'd0, 10'd9,    10'd9, 10'd1023, 1};
    vecs[5] = '{10'd3, 10'd8, 10'd3,    10'd9, 10'd1023, 2};
    vecs[6] = '{10'd3, 10'd8, 10'd1023, 10'd3, 10'd1022, 0};

    // reset
    repeat (3) step_clk();
    check("rst_state", state, ST_NOT_READY);
    check("rst_ready", ready, 1'b0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_tvalid", tx_tvalid, 1'b0);
    check("rst_tx_ack", tx_ack, 1'b0);
    check("rst_cmd_header", cmd_header, '0);
    check_cnts("rst");
    rst = 1'b0;
    step_clk();
    check("nr_hold", state, ST_NOT_READY);
    channel_ok = 1'b1;
    step_clk();
    check("up_idle", state, ST_IDLE);
    check("up_ready", ready, 1'b1);

    // 1: deliver, latency 2, held under backpressure
    lo = 20'($urandom_range(0, 20'hFFFFF));
    h = mk_hdr(10'd3, 10'd5, 10'd2, lo);
    p = {$urandom, $urandom, $urandom, $urandom};
    cmd_exp_q.push_back({h, p});
    rx_pkt(h, p, 2, 3);
    exp_rx++;
    check("t1_lat1_valid", cmd_valid, 1'b0);
    step_clk();
    check("t1_lat2_valid", cmd_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t1_hold_valid", cmd_valid, 1'b1);
      check("t1_hold_hdr", cmd_header, h);
      check("t1_hold_data", cmd_data, p);
      check("t1_tx_idle", tx_tvalid, 1'b0);
      step_clk();
    end
    cmd_ready = 1'b1;
    step_clk();
    cmd_ready = 1'b0;
    check("t1_after_hs", state, ST_IDLE);
    check_cnts("t1");

    // 2: forward with step+1, latency 2
    tx_tready = 1'b1;
    lo = 20'($urandom_range(0, 20'hFFFFF));
    h = mk_hdr(10'd7, 10'd5, 10'd4, lo);
    p = {$urandom, $urandom, $urandom, $urandom};
    push_fwd(10'd7, 10'd5, 10'd4, lo, p);
    rx_pkt(h, p, 2, 3);
    exp_rx++;
    check("t2_lat1_tvalid", tx_tvalid, 1'b0);
    step_clk();
    check("t2_lat2_tvalid", tx_tvalid, 1'b1);
    wait_done("t2_done", 20);
    check("t2_no_cmd", cmd_valid, 1'b0);
    check_cnts("t2");

    // 3: stale packet dropped
    h = mk_hdr(10'd7, 10'd5, 10'd1023, 20'd0);
    rx_pkt(h, p, 2, 3);
    exp_rx++;
    exp_drop++;
    wait_done("t3_done", 20);
    check_cnts("t3");

    // routing table
    cmd_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      id_i = vecs[v].id;
      nn_i = vecs[v].nn;
      lo = 20'($urandom_range(0, 20'hFFFFF));
      h = mk_hdr(vecs[v].dst, vecs[v].src, vecs[v].step, lo);
      p = {$urandom, $urandom, $urandom, $urandom};
      if (vecs[v].kind == 0) cmd_exp_q.push_back({h, p});
      else if (vecs[v].kind == 1) push_fwd(vecs[v].dst, vecs[v].src, vecs[v].step, lo, p);
      else exp_drop++;
      exp_rx++;
      rx_pkt(h, p, 2, 3);
      wait_done($sformatf("vec%0d_done", v), 20);
      check_cnts($sformatf("vec%0d", v));
    end
    id_i = 10'd3;
    nn_i = 10'd8;

    // 4: local TX with toggling tready, ack held until req falls
    tx_header = mk_hdr(10'd12, 10'd3, 10'd0, 20'h0ABCD);
    tx_data = {$urandom, $urandom, $urandom, $urandom};
    tx_exp_q.push_back({1'b0, tx_header});
    tx_exp_q.push_back({1'b0, tx_data[DW-1:0]});
    tx_exp_q.push_back({1'b1, tx_data[2*DW-1:DW]});
    tx_req = 1'b1;
    n = 0;
    while (tx_exp_q.size() != 0 && n < 40) begin
      step_clk();
      tx_tready = ~tx_tready;
      n++;
    end
    check("t4_sent", (n < 40), 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t4_ack_held", tx_ack, 1'b1);
      check("t4_wait_state", state, ST_WAIT_NREQ);
      step_clk();
    end
    tx_req = 1'b0;
    step_clk();
    check("t4_ack_low", tx_ack, 1'b0);
    check("t4_idle", state, ST_IDLE);

    // 5: timeout in TX_D
    tx_tready = 1'b1;
    tx_exp_q.push_back({1'b0, tx_header});
    tx_req = 1'b1;
    step_clk();
    check("t5_tx_h", state, ST_TX_H);
    n = 0;
    while (state != ST_NOT_READY && n < 600) begin
      step_clk();
      tx_tready = 1'b0;
      n++;
    end
    tx_req = 1'b0;
    exp_drop++;
    check("t5_timeout_cycles", n, 512);
    check("t5_ready_low", ready, 1'b0);
    check("t5_ack_low", tx_ack, 1'b0);
    check_cnts("t5");
    step_clk();
    check("t5_recover", state, ST_IDLE);
    tx_tready = 1'b1;

    // 6: early tlast, late tlast, normal delivery, link loss mid-RX
    h = mk_hdr(10'd3, 10'd5, 10'd1, 20'd1);
    p = {$urandom, $urandom, $urandom, $urandom};
    rx_pkt(h, p, 1, 2);
    exp_rx++;
    exp_drop++;
    wait_done("t6_early_done", 20);
    check_cnts("t6_early");
    rx_pkt(h, p, 3, 4);
    exp_rx++;
    exp_drop++;
    wait_done("t6_late_done", 20);
    check_cnts("t6_late");
    p = {$urandom, $urandom, $urandom, $urandom};
    cmd_exp_q.push_back({h, p});
    rx_pkt(h, p, 2, 3);
    exp_rx++;
    wait_done("t6_good_done", 20);
    check_cnts("t6_good");
    rx_pkt(h, p, -1, 2);
    channel_ok = 1'b0;
    step_clk();
    exp_drop++;
    check("t6_nr_state", state, ST_NOT_READY);
    check("t6_nr_ready", ready, 1'b0);
    check("t6_nr_cmd", cmd_valid, 1'b0);
    check_cnts("t6_nr");
    channel_ok = 1'b1;
    step_clk();
    check("t6_back_idle", state, ST_IDLE);
    check("t6_queues_empty", tx_exp_q.size() + cmd_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
